enet_nios_ext_mac_bus_ctl: RTL and testbench
============================================

Name: enet_nios_ext_mac_bus_ctl

Overview:
Avalon-MM slave that bridges Nios data-master accesses onto the asynchronous 16-bit host bus of the external Ethernet MAC/PHY chip. It drives chip-select, read and write strobes with programmable setup, strobe and hold timing, and stretches the strobe on the chip's ARDY line. It sits between the enet_nios Avalon fabric and the board-level MAC pins. It is the bus initiator for the chip; the MAC's bus interface is the responder.

Parameters:
ADDR_W, 4, external register address width (word address)
SETUP_CYC, 1, clk cycles with address/cs valid before strobe (1..15)
STROBE_CYC, 3, minimum strobe-active cycles (1..15)
HOLD_CYC, 1, cycles address/data held after strobe release (1..15)
TIMEOUT_CYC, 255, max extra strobe cycles waiting on ARDY (used only with the optional feature)

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
address  in  ADDR_W  Avalon word address
chipselect  in  1  Avalon select
read  in  1  Avalon read request
write  in  1  Avalon write request
byteenable  in  2  Avalon byte lanes
writedata  in  16  Avalon write data
readdata  out  16  Avalon read data
waitrequest  out  1  Avalon stall
ext_addr  out  ADDR_W  MAC register address
ext_be_n  out  2  MAC byte enables, active low
ext_cs_n  out  1  MAC chip select
ext_rd_n  out  1  MAC read strobe
ext_wr_n  out  1  MAC write strobe
ext_data_out  out  16  data to MAC
ext_data_oe  out  1  tri-state enable for ext data pins
ext_data_in  in  16  data from MAC
ext_ardy  in  1  MAC ready, asynchronous, active high
bus_err  out  1  sticky timeout flag (driven 0 when the optional feature is off)

Behaviour:
- Reset values: readdata=0, ext_addr=0, ext_be_n=2'b11, ext_cs_n=1, ext_rd_n=1, ext_wr_n=1, ext_data_out=0, ext_data_oe=0, bus_err=0, FSM=IDLE.
- ext_ardy passes through a 2-flop synchronizer (reset 0) to give ardy_s.
- FSM states: IDLE -> SETUP -> STROBE -> HOLD -> DONE -> IDLE. All ext_* outputs are registered.
- IDLE: when chipselect & (read|write), latch address, byteenable, writedata and direction. Write has priority if read and write are asserted together. Go to SETUP and load the down-counter with SETUP_CYC-1.
- SETUP: ext_cs_n=0, ext_addr and ext_be_n valid. For writes, ext_data_oe=1. When the counter reaches 0, go to STROBE and load STROBE_CYC-1.
- STROBE: ext_rd_n or ext_wr_n = 0. Leave when the counter is 0 and ardy_s=1. If ardy_s=0 at that point, stay (strobe extended). On the exit edge, reads capture ext_data_in into readdata.
- HOLD: strobes = 1. ext_cs_n, address and data are held for HOLD_CYC cycles, then go to DONE.
- DONE: ext_cs_n=1, ext_data_oe=0. Go to IDLE next cycle.
- waitrequest = chipselect & (read|write) & (state != DONE). This is combinational, so the Avalon master completes in DONE.
- Latency with defaults and ardy_s=1: waitrequest deasserts in the 7th cycle of the request (IDLE 1 + SETUP 1 + STROBE 3 + HOLD 1 + DONE 1).
- A master that drops chipselect mid-transaction does not abort it. The external cycle finishes, and a new request is accepted only in IDLE.
- readdata holds its last value until the next completed read. Writes do not alter readdata.
- reset_n asserted mid-cycle: all outputs return immediately (asynchronously) to their reset values. No partial strobe is extended.
- Counter widths are 4 bits. Parameter value 0 is illegal.

Optional Feature:
ENET_NIOS_ARDY_TIMEOUT_EN
- Defined: a TIMEOUT_CYC-wide counter runs while STROBE is extended by ardy_s=0. On reaching TIMEOUT_CYC, force exit to HOLD. For reads, readdata=16'hDEAD. bus_err sets to 1 and stays set until reset. A completed transfer does not clear it.
- Undefined: the strobe waits on ARDY indefinitely, there is no timeout logic, and bus_err is tied 0.

Test Plan:
- Reset, then a read of address 4'h3 with ext_data_in=16'h1234 and ardy=1 -> ext_rd_n low for exactly 3 cycles, waitrequest low in the 7th cycle, readdata=16'h1234.
- Write of 16'hA55A to address 4'h5 with byteenable=2'b01 -> ext_wr_n low 3 cycles, ext_be_n=2'b10, ext_data_oe=1 from SETUP through HOLD, ext_data_out=16'hA55A.
- Read with ardy held low for 5 extra cycles -> strobe lasts 3 + 5 + 2 (synchronizer) cycles, and data is captured only after ardy_s rises.
- Read and write asserted together -> only ext_wr_n pulses and readdata is unchanged. Also: reset_n pulsed low during STROBE -> ext_cs_n/ext_rd_n go to 1 without waiting for a clock edge, and the FSM is in IDLE.
- With ENET_NIOS_ARDY_TIMEOUT_EN and TIMEOUT_CYC=8, ardy stuck low on a read -> exit after 8 extra cycles, readdata=16'hDEAD, bus_err=1. A following good read leaves bus_err=1.
- Back-to-back writes with the master holding chipselect -> the second external cycle starts from IDLE the cycle after DONE, with ext_cs_n high for at least 1 cycle between cycles.

Source files
------------

// File: rtl/enet_nios_ext_mac_bus_ctl.sv
// enet_nios_ext_mac_bus_ctl: Avalon-MM slave driving the async 16-bit host bus of the external MAC/PHY
// Optional ARDY timeout with sticky bus_err: define ENET_NIOS_ARDY_TIMEOUT_EN
module enet_nios_ext_mac_bus_ctl #(
    parameter int ADDR_W      = 4,
    parameter int SETUP_CYC   = 1,
    parameter int STROBE_CYC  = 3,
    parameter int HOLD_CYC    = 1,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] address,
    input  logic              chipselect,
    input  logic              read,
    input  logic              write,
    input  logic [1:0]        byteenable,
    input  logic [15:0]       writedata,
    output logic [15:0]       readdata,
    output logic              waitrequest,
    output logic [ADDR_W-1:0] ext_addr,
    output logic [1:0]        ext_be_n,
    output logic              ext_cs_n,
    output logic              ext_rd_n,
    output logic              ext_wr_n,
    output logic [15:0]       ext_data_out,
    output logic              ext_data_oe,
    input  logic [15:0]       ext_data_in,
    input  logic              ext_ardy,
    output logic              bus_err
);
    typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, DONE} state_t;

    localparam bit CFG_OK = SETUP_CYC >= 1 && SETUP_CYC <= 15 && STROBE_CYC >= 1 && STROBE_CYC <= 15 &&
                            HOLD_CYC >= 1 && HOLD_CYC <= 15 && TIMEOUT_CYC >= 1;

    state_t      state, nxt;
    logic [3:0]  cnt;
    logic [1:0]  ardy_sync;
    logic        ardy_s, req, accept, wr_q, timeout, active_nxt;

    assign ardy_s      = ardy_sync[1];
    assign req         = chipselect & (read | write);
    assign accept      = (state == IDLE) && req;
    assign waitrequest = req && (state != DONE);
    assign active_nxt  = (nxt == SETUP) || (nxt == STROBE) || (nxt == HOLD);

    cfg_chk: assert property (@(posedge clk) CFG_OK);

    // two-flop synchronizer for the asynchronous ready line
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) ardy_sync <= 2'b00;
        else          ardy_sync <= {ardy_sync[0], ext_ardy};

`ifdef ENET_NIOS_ARDY_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    logic [TW-1:0] tcnt;
    logic          waiting;

    assign waiting = (state == STROBE) && (cnt == 4'd0) && !ardy_s;
    assign timeout = waiting && (tcnt == TW'(TIMEOUT_CYC));

    // counts strobe-extension cycles; bus_err is sticky until reset
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            tcnt    <= '0;
            bus_err <= 1'b0;
        end else begin
            tcnt    <= waiting ? tcnt + 1'b1 : '0;
            bus_err <= bus_err | timeout;
        end
`else
    assign timeout = 1'b0;
    assign bus_err = 1'b0;
`endif

    // state register with phase down-counter reloaded on every transition
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= nxt;
            cnt   <= (nxt != state) ? ((nxt == SETUP)  ? 4'(SETUP_CYC - 1)  :
                                       (nxt == STROBE) ? 4'(STROBE_CYC - 1) :
                                       (nxt == HOLD)   ? 4'(HOLD_CYC - 1)   : 4'd0)
                                    : ((cnt != 4'd0) ? cnt - 4'd1 : cnt);
        end

    // next-state: strobe stretches until the minimum elapses and ready is seen (or timeout)
    always_comb begin
        nxt = state;
        case (state)
            IDLE:    if (req) nxt = SETUP;
            SETUP:   if (cnt == 4'd0) nxt = STROBE;
            STROBE:  if (cnt == 4'd0 && (ardy_s || timeout)) nxt = HOLD;
            HOLD:    if (cnt == 4'd0) nxt = DONE;
            default: nxt = IDLE;
        endcase
    end

    // registered bus outputs, decoded from the state being entered
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            readdata     <= 16'h0000;
            ext_addr     <= '0;
            ext_be_n     <= 2'b11;
            ext_cs_n     <= 1'b1;
            ext_rd_n     <= 1'b1;
            ext_wr_n     <= 1'b1;
            ext_data_out <= 16'h0000;
            ext_data_oe  <= 1'b0;
            wr_q         <= 1'b0;
        end else begin
            if (accept) begin
                ext_addr     <= address;
                ext_data_out <= writedata;
                wr_q         <= write;
            end
            ext_be_n    <= accept ? ~byteenable : ((nxt == DONE) ? 2'b11 : ext_be_n);
            ext_cs_n    <= !active_nxt;
            ext_rd_n    <= !((nxt == STROBE) && !wr_q);
            ext_wr_n    <= !((nxt == STROBE) && wr_q);
            ext_data_oe <= active_nxt && (accept ? write : wr_q);
            if (state == STROBE && nxt == HOLD && !wr_q)
                readdata <= timeout ? 16'hDEAD : ext_data_in;
        end
endmodule

// File: tb/tb_enet_nios_ext_mac_bus_ctl.sv
// tb_enet_nios_ext_mac_bus_ctl: scoreboard bench for the external MAC bus controller
module tb_enet_nios_ext_mac_bus_ctl;
    logic        clk = 1'b0, reset_n = 1'b0;
    logic [3:0]  address = '0;
    logic        chipselect = 1'b0, read = 1'b0, write = 1'b0;
    logic [1:0]  byteenable = 2'b00;
    logic [15:0] writedata = '0, readdata, ext_data_out, ext_data_in = '0;
    logic        waitrequest, ext_cs_n, ext_rd_n, ext_wr_n, ext_data_oe, bus_err;
    logic        ext_ardy = 1'b1;
    logic [3:0]  ext_addr;
    logic [1:0]  ext_be_n;

    int n_chk = 0, n_fail = 0;
    logic [15:0] model_rd = 16'h0000;

    typedef struct {
        int lat; int rdl; int wrl; int oe;
        logic [3:0] addr; logic [1:0] be_n; logic [15:0] dout; logic [15:0] rdata;
        logic first_cs; logic last_cs; logic early;
    } xfer_t;
    xfer_t exp_q[$];

    enet_nios_ext_mac_bus_ctl #(.ADDR_W(4), .SETUP_CYC(1), .STROBE_CYC(3), .HOLD_CYC(1), .TIMEOUT_CYC(8)) dut (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect), .read(read),
        .write(write), .byteenable(byteenable), .writedata(writedata), .readdata(readdata),
        .waitrequest(waitrequest), .ext_addr(ext_addr), .ext_be_n(ext_be_n), .ext_cs_n(ext_cs_n),
        .ext_rd_n(ext_rd_n), .ext_wr_n(ext_wr_n), .ext_data_out(ext_data_out),
        .ext_data_oe(ext_data_oe), .ext_data_in(ext_data_in), .ext_ardy(ext_ardy), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    // expected outcome of one transfer; strobe is 3 cycles plus any ARDY extension
    function automatic xfer_t expect_xfer(input bit wr, input logic [3:0] a, input logic [1:0] be,
                                          input logic [15:0] wd, input int extra);
        xfer_t e;
        e.lat = 7 + extra;
        e.rdl = wr ? 0 : 3 + extra;
        e.wrl = wr ? 3 + extra : 0;
        e.oe = wr ? 5 + extra : 0;
        e.addr = a;
        e.be_n = ~be;
        e.dout = wd;
        e.rdata = model_rd;
        e.first_cs = 1'b1;
        e.last_cs = 1'b1;
        e.early = 1'b0;
        return e;
    endfunction

    // runs one Avalon transfer, measures the external cycle and checks it against the scoreboard
    task automatic do_xfer(input string name, input bit wr, input bit rd, input logic [3:0] a,
                           input logic [1:0] be, input logic [15:0] wd, input bit keep, input int ardy_rise);
        xfer_t o, e;
        logic [15:0] rd0;
        o.lat = 1; o.rdl = 0; o.wrl = 0; o.oe = 0; o.early = 1'b0;
        o.addr = 'x; o.be_n = 'x; o.dout = 'x;
        @(negedge clk);
        chipselect = 1'b1; read = rd; write = wr; address = a; byteenable = be; writedata = wd;
        #1;
        rd0 = readdata;
        o.first_cs = ext_cs_n;
        while (waitrequest && o.lat < 100) begin
            @(negedge clk);
            o.lat++;
            if (!ext_rd_n) o.rdl++;
            if (!ext_wr_n) o.wrl++;
            if (ext_data_oe) o.oe++;
            if (!ext_rd_n || !ext_wr_n) begin
                o.addr = ext_addr; o.be_n = ext_be_n; o.dout = ext_data_out;
                if (readdata !== rd0) o.early = 1'b1;
                if (ardy_rise > 0 && o.rdl + o.wrl == ardy_rise) ext_ardy = 1'b1;
            end
        end
        o.last_cs = ext_cs_n;
        o.rdata = readdata;
        if (!keep) begin chipselect = 1'b0; read = 1'b0; write = 1'b0; end
        e = exp_q.pop_front();
        n_chk++; if (waitrequest !== 1'b0) begin n_fail++; $display("FAIL %s done: waitrequest=%b required 0 within 100 cycles", name, waitrequest); end
        n_chk++; if (o.lat !== e.lat) begin n_fail++; $display("FAIL %s latency: got %0d required %0d", name, o.lat, e.lat); end
        n_chk++; if (o.rdl !== e.rdl) begin n_fail++; $display("FAIL %s rd_n low cycles: got %0d required %0d", name, o.rdl, e.rdl); end
        n_chk++; if (o.wrl !== e.wrl) begin n_fail++; $display("FAIL %s wr_n low cycles: got %0d required %0d", name, o.wrl, e.wrl); end
        n_chk++; if (o.oe !== e.oe) begin n_fail++; $display("FAIL %s data_oe cycles: got %0d required %0d", name, o.oe, e.oe); end
        n_chk++; if (o.addr !== e.addr) begin n_fail++; $display("FAIL %s ext_addr: got %h required %h", name, o.addr, e.addr); end
        n_chk++; if (o.be_n !== e.be_n) begin n_fail++; $display("FAIL %s ext_be_n: got %b required %b", name, o.be_n, e.be_n); end
        n_chk++; if (o.dout !== e.dout) begin n_fail++; $display("FAIL %s ext_data_out: got %h required %h", name, o.dout, e.dout); end
        n_chk++; if (o.rdata !== e.rdata) begin n_fail++; $display("FAIL %s readdata: got %h required %h", name, o.rdata, e.rdata); end
        n_chk++; if (o.first_cs !== e.first_cs) begin n_fail++; $display("FAIL %s cs_n at request: got %b required %b", name, o.first_cs, e.first_cs); end
        n_chk++; if (o.last_cs !== e.last_cs) begin n_fail++; $display("FAIL %s cs_n at done: got %b required %b", name, o.last_cs, e.last_cs); end
        n_chk++; if (o.early !== e.early) begin n_fail++; $display("FAIL %s early capture: got %b required %b", name, o.early, e.early); end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        #12;
        n_chk++; if (readdata !== 16'h0) begin n_fail++; $display("FAIL reset readdata: got %h required 0000", readdata); end
        n_chk++; if (ext_addr !== 4'h0) begin n_fail++; $display("FAIL reset ext_addr: got %h required 0", ext_addr); end
        n_chk++; if (ext_be_n !== 2'b11) begin n_fail++; $display("FAIL reset ext_be_n: got %b required 11", ext_be_n); end
        n_chk++; if ({ext_cs_n, ext_rd_n, ext_wr_n} !== 3'b111) begin n_fail++; $display("FAIL reset strobes: got %b required 111", {ext_cs_n, ext_rd_n, ext_wr_n}); end
        n_chk++; if (ext_data_out !== 16'h0 || ext_data_oe !== 1'b0) begin n_fail++; $display("FAIL reset data: got %h/%b required 0000/0", ext_data_out, ext_data_oe); end
        n_chk++; if (bus_err !== 1'b0 || waitrequest !== 1'b0) begin n_fail++; $display("FAIL reset err/wait: got %b/%b required 0/0", bus_err, waitrequest); end
        @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_read();
        ext_ardy = 1'b1; ext_data_in = 16'h1234; model_rd = 16'h1234;
        exp_q.push_back(expect_xfer(1'b0, 4'h3, 2'b11, 16'h0, 0));
        do_xfer("read", 1'b0, 1'b1, 4'h3, 2'b11, 16'h0, 1'b0, 0);
    endtask

    task automatic test_write();
        ext_data_in = 16'hFFFF;
        exp_q.push_back(expect_xfer(1'b1, 4'h5, 2'b01, 16'hA55A, 0));
        do_xfer("write", 1'b1, 1'b0, 4'h5, 2'b01, 16'hA55A, 1'b0, 0);
    endtask

    task automatic test_ardy_stretch();
        ext_ardy = 1'b0; ext_data_in = 16'hC0DE; model_rd = 16'hC0DE;
        exp_q.push_back(expect_xfer(1'b0, 4'h9, 2'b10, 16'h0, 7));
        do_xfer("ardy_stretch", 1'b0, 1'b1, 4'h9, 2'b10, 16'h0, 1'b0, 8);
        ext_ardy = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_rd_wr_priority();
        ext_data_in = 16'h5555;
        exp_q.push_back(expect_xfer(1'b1, 4'hC, 2'b11, 16'h0F0F, 0));
        do_xfer("rd_wr_priority", 1'b1, 1'b1, 4'hC, 2'b11, 16'h0F0F, 1'b0, 0);
    endtask

    task automatic test_reset_mid_strobe();
        int k;
        ext_data_in = 16'h7777;
        @(negedge clk);
        chipselect = 1'b1; read = 1'b1; address = 4'h2; byteenable = 2'b11;
        k = 0;
        while (ext_rd_n !== 1'b0 && k < 20) begin @(negedge clk); k++; end
        n_chk++; if (ext_rd_n !== 1'b0) begin n_fail++; $display("FAIL midreset strobe start: rd_n=%b required 0", ext_rd_n); end
        #2 reset_n = 1'b0;
        #1;
        n_chk++; if (ext_cs_n !== 1'b1 || ext_rd_n !== 1'b1) begin n_fail++; $display("FAIL midreset async: cs_n/rd_n=%b%b required 11", ext_cs_n, ext_rd_n); end
        n_chk++; if (readdata !== 16'h0) begin n_fail++; $display("FAIL midreset readdata: got %h required 0000", readdata); end
        n_chk++; if (waitrequest !== 1'b1) begin n_fail++; $display("FAIL midreset waitrequest: got %b required 1", waitrequest); end
        chipselect = 1'b0; read = 1'b0;
        model_rd = 16'h0;
        @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        ext_data_in = 16'h2468; model_rd = 16'h2468;
        exp_q.push_back(expect_xfer(1'b0, 4'h1, 2'b11, 16'h0, 0));
        do_xfer("after_reset_read", 1'b0, 1'b1, 4'h1, 2'b11, 16'h0, 1'b0, 0);
    endtask

    task automatic test_back_to_back();
        exp_q.push_back(expect_xfer(1'b1, 4'h6, 2'b11, 16'h1111, 0));
        exp_q.push_back(expect_xfer(1'b1, 4'h7, 2'b10, 16'h2222, 0));
        do_xfer("b2b_first", 1'b1, 1'b0, 4'h6, 2'b11, 16'h1111, 1'b1, 0);
        do_xfer("b2b_second", 1'b1, 1'b0, 4'h7, 2'b10, 16'h2222, 1'b0, 0);
    endtask

`ifdef ENET_NIOS_ARDY_TIMEOUT_EN
    task automatic test_timeout();
        ext_ardy = 1'b0; ext_data_in = 16'hBEEF; model_rd = 16'hDEAD;
        repeat (2) @(negedge clk);
        exp_q.push_back(expect_xfer(1'b0, 4'hA, 2'b11, 16'h0, 8));
        do_xfer("timeout", 1'b0, 1'b1, 4'hA, 2'b11, 16'h0, 1'b0, 0);
        n_chk++; if (bus_err !== 1'b1) begin n_fail++; $display("FAIL timeout bus_err: got %b required 1", bus_err); end
        ext_ardy = 1'b1; ext_data_in = 16'h4321; model_rd = 16'h4321;
        repeat (2) @(negedge clk);
        exp_q.push_back(expect_xfer(1'b0, 4'hB, 2'b11, 16'h0, 0));
        do_xfer("post_timeout_read", 1'b0, 1'b1, 4'hB, 2'b11, 16'h0, 1'b0, 0);
        n_chk++; if (bus_err !== 1'b1) begin n_fail++; $display("FAIL sticky bus_err: got %b required 1", bus_err); end
    endtask
`else
    task automatic test_timeout();
        n_chk++; if (bus_err !== 1'b0) begin n_fail++; $display("FAIL bus_err tied: got %b required 0", bus_err); end
    endtask
`endif

    initial begin
        test_reset();
        test_read();
        test_write();
        test_ardy_stretch();
        test_rd_wr_priority();
        test_reset_mid_strobe();
        test_back_to_back();
        test_timeout();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
